player_hit_manager: RTL

- Downstream consumer of the enemy-ammunition stage: takes the bullet position (posX_Municao2/posY_Municao2) and the player ship position, and detects bullet/ship overlap.
- Owns the player life counter, post-hit invulnerability window, ship blink control and the game-over flag.
- Outputs feed the ship renderer (visibility), the HUD (lives) and the top-level game FSM (game_over).

---
 rtl/player_hit_manager.sv | 135 +++++++++++++
 1 files changed

// File: rtl/player_hit_manager.sv
// rtl/player_hit_manager.sv - bullet/ship hit detection, lives, invulnerability and blink control
module player_hit_manager #(
    parameter int VIDAS_INICIAIS = 3,
    parameter int NAVE_W         = 40,
    parameter int NAVE_H         = 20,
    parameter int MUNICAO_H      = 20,
    parameter int INVUL_CYCLES   = 100000000,
    parameter int BLINK_CYCLES   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] posX_Municao2,
    input  logic [10:0] posY_Municao2,
    input  logic [10:0] posX_nave,
    input  logic [10:0] posY_nave,
    output logic        hit,
    output logic [2:0]  vidas,
    output logic        invulneravel,
    output logic        nave_visivel,
    output logic        game_over
);

    localparam int INV_W = $clog2(INVUL_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVUL_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [11:0] MH1 = 12'(MUNICAO_H - 1);
    localparam logic [11:0] NW1 = 12'(NAVE_W - 1);
    localparam logic [11:0] NH1 = 12'(NAVE_H - 1);

    typedef enum logic [1:0] {JOGANDO, INVULNERAVEL, GAME_OVER} state_t;

    state_t             state_q, state_d;
    logic [INV_W-1:0]   inv_cnt, inv_cnt_d;
    logic [BLK_W-1:0]   blink_cnt, blink_cnt_d;
    logic               overlap, overlap_q, armed, armed_d;
    logic               hit_d, invul_d, vis_d, go_d;
    logic [2:0]         vidas_d;
    logic [11:0]        bx, by, btop, px, py;

    // 12-bit operands so box edge sums never wrap
    assign bx   = {1'b0, posX_Municao2};
    assign by   = {1'b0, posY_Municao2};
    assign px   = {1'b0, posX_nave};
    assign py   = {1'b0, posY_nave};
    assign btop = (by < MH1) ? 12'd0 : by - MH1;

    assign overlap = (by != 12'd0) && (bx >= px) && (bx <= px + NW1)
                     && (btop <= py + NH1) && (by >= py);

    always_comb begin
        state_d     = state_q;
        hit_d       = 1'b0;
        vidas_d     = vidas;
        invul_d     = invulneravel;
        vis_d       = nave_visivel;
        go_d        = game_over;
        inv_cnt_d   = inv_cnt;
        blink_cnt_d = blink_cnt;
        armed_d     = armed | ~overlap_q;
        case (state_q)
            JOGANDO: begin
                invul_d = 1'b0;
                vis_d   = 1'b1;
                if (overlap_q && armed) begin
                    hit_d   = 1'b1;
                    armed_d = 1'b0;
                    if (vidas <= 3'd1) begin
                        state_d = GAME_OVER;
                        vidas_d = 3'd0;
                        go_d    = 1'b1;
                        vis_d   = 1'b0;
                    end else begin
                        state_d     = INVULNERAVEL;
                        vidas_d     = vidas - 3'd1;
                        invul_d     = 1'b1;
                        inv_cnt_d   = '0;
                        blink_cnt_d = '0;
                    end
                end
            end
            INVULNERAVEL: begin
                if (inv_cnt == INV_LAST) begin
                    state_d     = JOGANDO;
                    invul_d     = 1'b0;
                    vis_d       = 1'b1;
                    inv_cnt_d   = '0;
                    blink_cnt_d = '0;
                end else begin
                    inv_cnt_d = inv_cnt + INV_W'(1);
                    if (blink_cnt == BLK_LAST) begin
                        blink_cnt_d = '0;
                        vis_d       = ~nave_visivel;
                    end else begin
                        blink_cnt_d = blink_cnt + BLK_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                go_d    = 1'b1;
                vis_d   = 1'b0;
                invul_d = 1'b0;
                vidas_d = 3'd0;
            end
            default: state_d = JOGANDO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= JOGANDO;
            hit          <= 1'b0;
            vidas        <= 3'(VIDAS_INICIAIS);
            invulneravel <= 1'b0;
            nave_visivel <= 1'b1;
            game_over    <= 1'b0;
            overlap_q    <= 1'b0;
            armed        <= 1'b1;
            inv_cnt      <= '0;
            blink_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            hit          <= hit_d;
            vidas        <= vidas_d;
            invulneravel <= invul_d;
            nave_visivel <= vis_d;
            game_over    <= go_d;
            overlap_q    <= overlap;
            armed        <= armed_d;
            inv_cnt      <= inv_cnt_d;
            blink_cnt    <= blink_cnt_d;
        end
    end

endmodule
